wb_timing_arbiter: RTL and testbench

WB_TIMING_ARBITER -- requirements
Module: wb_timing_arbiter

---
 rtl/wb_timing_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_timing_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timing_arbiter.sv
// Two-master Wishbone arbiter onto one shared slave, with round-robin grant,
// per-transfer latency capture and timeout error termination.
module wb_timing_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic [7:0]  last_lat_o,
  output logic [7:0]  tmo_cnt_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 0 = master 0, 1 = master 1
  logic            rr_q, rr_d;         // master favoured on a tie
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last_lat_q, last_lat_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   resp_q, resp_d;

  logic            req0, req1, owner_cyc;
  logic [CW-1:0]   cnt_inc;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign cnt_inc   = cnt_q + CW'(1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      last_lat_q <= '0;
      tmo_q      <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      last_lat_q <= last_lat_d;
      tmo_q      <= tmo_d;
      resp_q     <= resp_d;
    end
  end

  // Next-state: arbitration, wait counting, ack/timeout/abort resolution
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    last_lat_d = last_lat_q;
    tmo_d      = tmo_q;
    resp_d     = resp_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? rr_q : req1;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Ack has priority over both abort and timeout
        if (s_ack_i) begin
          resp_d     = s_dat_i;
          err_d      = 1'b0;
          last_lat_d = cnt_inc;
          rr_d       = ~owner_q;
          state_d    = RESP;
        end else if (!owner_cyc) begin
          state_d = IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          resp_d     = '0;
          err_d      = 1'b1;
          last_lat_d = cnt_inc;
          tmo_d      = (tmo_q == '1) ? tmo_q : tmo_q + CW'(1);
          rr_d       = ~owner_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; slave request muxes owner inputs
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    grant_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      XFER: begin
        s_cyc_o = 1'b1;
        s_stb_o = 1'b1;
        s_we_o  = owner_q ? m1_we_i  : m0_we_i;
        s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
        s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
        s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
        grant_o = owner_q ? 2'b10 : 2'b01;
      end
      RESP: begin
        grant_o = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          m1_ack_o = ~err_q;
          m1_err_o = err_q;
          m1_dat_o = resp_q;
        end else begin
          m0_ack_o = ~err_q;
          m0_err_o = err_q;
          m0_dat_o = resp_q;
        end
      end
      default: ;
    endcase
  end

  assign last_lat_o = last_lat_q;
  assign tmo_cnt_o  = tmo_q;

endmodule

// File: tb/tb_wb_timing_arbiter.sv
// Scoreboard bench for wb_timing_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a master sees ack or err.
module tb_wb_timing_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic [7:0]  last_lat, tmo_cnt;

  typedef struct packed {
    logic        m;
    logic        e;
    logic [31:0] d;
    logic [7:0]  lat;
    logic [7:0]  tmo;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_at = 0;
  int          xcnt   = 0;
  logic [31:0] ack_data = '0;

  always #5 clk = ~clk;

  wb_timing_arbiter #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .last_lat_o(last_lat), .tmo_cnt_o(tmo_cnt)
  );

  assign s_rdat = ack_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: acks in XFER cycle number ack_at (0 = never)
  always @(negedge clk) begin
    if (s_cyc && s_stb) begin
      xcnt  = xcnt + 1;
      s_ack = (ack_at != 0) && (xcnt == ack_at);
    end else begin
      xcnt  = 0;
      s_ack = 1'b0;
    end
  end

  // Monitor: every ack/err cycle must match the head of the queue
  always @(negedge clk) begin
    logic r0, r1;
    exp_t e;
    if (rst_n === 1'b1) begin
      r0 = m0_ack | m0_err;
      r1 = m1_ack | m1_err;
      if (r0 || r1) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {30'b0, r1, r0}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp_owner", {30'b0, r1, r0}, e.m ? 32'd2 : 32'd1);
          chk("resp_kind", e.m ? {30'b0, m1_ack, m1_err} : {30'b0, m0_ack, m0_err},
              e.e ? 32'd1 : 32'd2);
          chk("resp_dat", e.m ? m1_rdat : m0_rdat, e.d);
          chk("other_dat", e.m ? m0_rdat : m1_rdat, 32'd0);
          chk("last_lat", {24'b0, last_lat}, {24'b0, e.lat});
          chk("tmo_cnt", {24'b0, tmo_cnt}, {24'b0, e.tmo});
        end
      end else begin
        chk("quiet_dat", m0_rdat | m1_rdat, 32'd0);
      end
    end
  end

  task automatic wait_empty(input string nm, input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d responses pending after %0d cycles, expected 0", nm, q.size(), maxc);
      q.delete();
    end
  endtask

  task automatic set_m(input int n, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (n == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat = dat;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rst_last_lat", {24'b0, last_lat}, 32'd0);
    chk("rst_tmo", {24'b0, tmo_cnt}, 32'd0);
    rst_n = 1'b1;

    // Both masters request continuously: strict alternation from master 0
    ack_at = 2; ack_data = 32'h0000_0033;
    for (int i = 0; i < 6; i++) q.push_back('{m: 1'(i % 2), e: 1'b0, d: 32'h33, lat: 8'd2, tmo: 8'd0});
    set_m(0, 1'b1, 1'b0, 32'h0000_1000, '0);
    set_m(1, 1'b1, 1'b0, 32'h0000_2000, '0);
    wait_empty("rr_alternate", 100);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // m0 write, ack in first XFER cycle; slave request mirrors m0
    ack_at = 1; ack_data = 32'hDEAD_0001;
    q.push_back('{m: 1'b0, e: 1'b0, d: 32'hDEAD_0001, lat: 8'd1, tmo: 8'd0});
    set_m(0, 1'b1, 1'b1, 32'h3000_0000, 32'hA5A5_A5A5);
    @(posedge clk);
    @(negedge clk);
    chk("wr_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'd3);
    chk("wr_s_we", {31'b0, s_we}, 32'd1);
    chk("wr_s_sel", {28'b0, s_sel}, 32'hF);
    chk("wr_s_adr", s_adr, 32'h3000_0000);
    chk("wr_s_dat", s_wdat, 32'hA5A5_A5A5);
    chk("wr_grant", {30'b0, grant}, 32'd1);
    wait_empty("m0_write", 20);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    chk("idle_s_adr", s_adr, 32'd0);
    repeat (2) @(negedge clk);

    // m1 read, ack in third XFER cycle
    ack_at = 3; ack_data = 32'h1234_5678;
    q.push_back('{m: 1'b1, e: 1'b0, d: 32'h1234_5678, lat: 8'd3, tmo: 8'd0});
    set_m(1, 1'b1, 1'b0, 32'h3000_0004, '0);
    wait_empty("m1_read", 20);
    @(negedge clk);
    set_m(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // m0 read, slave never acks: timeout after 16 XFER cycles
    ack_at = 0; ack_data = 32'hFFFF_FFFF;
    q.push_back('{m: 1'b0, e: 1'b1, d: 32'h0, lat: 8'd16, tmo: 8'd1});
    set_m(0, 1'b1, 1'b0, 32'h3000_0008, '0);
    wait_empty("timeout", 40);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Ack exactly on the 16th XFER cycle wins over timeout
    ack_at = 16; ack_data = 32'hCAFE_0016;
    q.push_back('{m: 1'b0, e: 1'b0, d: 32'hCAFE_0016, lat: 8'd16, tmo: 8'd1});
    set_m(0, 1'b1, 1'b0, 32'h3000_000C, '0);
    wait_empty("ack_at_limit", 40);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // m1 drops cyc mid-transfer: abort, no response, latency unchanged
    ack_at = 0;
    set_m(1, 1'b1, 1'b0, 32'h3000_0010, '0);
    @(posedge clk);
    repeat (3) @(negedge clk);
    set_m(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("abort_grant", {30'b0, grant}, 32'd0);
    chk("abort_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("abort_last_lat", {24'b0, last_lat}, 32'd16);
    repeat (2) @(negedge clk);

    // Reset mid-XFER (pointer currently favours m1): outputs clear at once
    set_m(0, 1'b1, 1'b0, 32'h3000_0014, '0);
    @(posedge clk);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rstx_grant", {30'b0, grant}, 32'd0);
    chk("rstx_s_adr", s_adr, 32'd0);
    chk("rstx_tmo", {24'b0, tmo_cnt}, 32'd0);
    chk("rstx_last_lat", {24'b0, last_lat}, 32'd0);
    set_m(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_at = 1; ack_data = 32'h0000_0037;
    q.push_back('{m: 1'b0, e: 1'b0, d: 32'h37, lat: 8'd1, tmo: 8'd0});
    set_m(0, 1'b1, 1'b0, 32'h3000_0018, '0);
    set_m(1, 1'b1, 1'b0, 32'h3000_001C, '0);
    wait_empty("post_reset_rr", 20);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("end_grant", {30'b0, grant}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
